// File: rtl/phase_monitor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// phase_monitor_if : phase input and status outputs of phase_monitor.
// Capture ports exist only when PHASE_MON_CAPTURE_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
interface phase_monitor_if #(
    parameter int CNT_W = 16
);
    logic [0:7]       phase;
    logic [2:0]       ph_idx;
    logic             ph_valid;
    logic             onehot_err;
    logic             seq_err;
    logic             restart;
    logic             err_sticky;
    logic [CNT_W-1:0] loop_count;
    logic [1:0]       state;
`ifdef PHASE_MON_CAPTURE_EN
    logic [0:7]       cap_prev;
    logic [0:7]       cap_cur;

    modport master (
        output phase,
        input  ph_idx, ph_valid, onehot_err, seq_err, restart, err_sticky,
               loop_count, state, cap_prev, cap_cur
    );
    modport slave (
        input  phase,
        output ph_idx, ph_valid, onehot_err, seq_err, restart, err_sticky,
               loop_count, state, cap_prev, cap_cur
    );
`else
    modport master (
        output phase,
        input  ph_idx, ph_valid, onehot_err, seq_err, restart, err_sticky,
               loop_count, state
    );
    modport slave (
        input  phase,
        output ph_idx, ph_valid, onehot_err, seq_err, restart, err_sticky,
               loop_count, state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/phase_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// phase_monitor : decodes and checks the sequencer's one-hot phase, counts loops.
// Optional first-error capture under PHASE_MON_CAPTURE_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module phase_monitor #(
    parameter int CNT_W     = 16,
    parameter int LOOP_LAST = 5
) (
    input  logic           clock,
    input  logic           reset,
    phase_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_LOOP = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(LOOP_LAST - 1);

    state_t           state_q, state_d;
    logic [2:0]       ph_idx_q, ph_idx_d;
    logic             ph_valid_q, ph_valid_d;
    logic             onehot_err_q, onehot_err_d;
    logic             seq_err_q, seq_err_d;
    logic             restart_q, restart_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] loop_count_q, loop_count_d;

    logic [3:0]       w_ones;
    logic [2:0]       w_idx;
    logic             w_valid;
    logic             w_succ_ok;

    always_comb begin
        w_ones = '0;
        w_idx  = '0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'd0, bus.phase[i]};
            if (bus.phase[i]) w_idx = 3'(i);
        end
        w_valid = (w_ones == 4'd1);
    end

    // ph_idx_q / ph_valid_q double as the previous-sample history.
    assign w_succ_ok = ((ph_idx_q < LAST_IDX) && (w_idx == ph_idx_q + 3'd1)) ||
                       ((ph_idx_q == LAST_IDX) && (w_idx == 3'd1));

    always_comb begin
        state_d      = state_q;
        ph_idx_d     = 3'd0;
        ph_valid_d   = w_valid;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        restart_d    = 1'b0;
        loop_count_d = loop_count_q;

        if (!w_valid) begin
            onehot_err_d = 1'b1;
            state_d      = ST_WAIT;
        end else begin
            ph_idx_d  = w_idx;
            restart_d = (w_idx == 3'd0) && ph_valid_q && (ph_idx_q != 3'd0);
            case (state_q)
                ST_WAIT: begin
                    if (w_idx == 3'd0) state_d = ST_INIT;
                end
                ST_INIT: begin
                    if (w_idx == 3'd1) begin
                        state_d = ST_LOOP;
                    end else if (w_idx != 3'd0) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                ST_LOOP: begin
                    if (w_idx == 3'd0) begin
                        state_d = ST_INIT;
                    end else if (w_succ_ok) begin
                        if (ph_idx_q == LAST_IDX) loop_count_d = loop_count_q + 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end

        err_sticky_d = err_sticky_q | onehot_err_d | seq_err_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT;
            ph_idx_q     <= '0;
            ph_valid_q   <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            restart_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            loop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ph_idx_q     <= ph_idx_d;
            ph_valid_q   <= ph_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            restart_q    <= restart_d;
            err_sticky_q <= err_sticky_d;
            loop_count_q <= loop_count_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.ph_idx     = ph_idx_q;
    assign bus.ph_valid   = ph_valid_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.restart    = restart_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.loop_count = loop_count_q;

`ifdef PHASE_MON_CAPTURE_EN
    logic [0:7] prev_raw_q;
    logic [0:7] cap_prev_q, cap_prev_d;
    logic [0:7] cap_cur_q, cap_cur_d;

    // Only the rising edge of err_sticky loads the capture pair.
    always_comb begin
        cap_prev_d = cap_prev_q;
        cap_cur_d  = cap_cur_q;
        if (!err_sticky_q && err_sticky_d) begin
            cap_prev_d = prev_raw_q;
            cap_cur_d  = bus.phase;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_raw_q <= '0;
            cap_prev_q <= '0;
            cap_cur_q  <= '0;
        end else begin
            prev_raw_q <= bus.phase;
            cap_prev_q <= cap_prev_d;
            cap_cur_q  <= cap_cur_d;
        end
    end

    assign bus.cap_prev = cap_prev_q;
    assign bus.cap_cur  = cap_cur_q;
`endif
endmodule
`default_nettype wire

// File: doc/phase_monitor.md
Name: phase_monitor

Overview:
- Receive-side companion to the one-hot phase sequencer; consumes its 8-bit one-hot phase vector (PH1..PH8).
- Decodes the vector to a binary phase index and checks one-hot legality and transition legality against the sequencer's loop (PH1 → PH2..PH5 → PH2 ...).
- Counts completed loops.
- Sits beside the sequencer in the CPU control section; feeds debug/trap logic.

Parameters:
- CNT_W, 16, width of loop_count.
- LOOP_LAST, 5, highest phase number in the loop (1-based). PH<LOOP_LAST> wraps to PH2. Legal range 2..8.

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low. reset=0 forces reset state immediately.
- phase, input, [0:7], one-hot phase from sequencer. Bit 0 = PH1 … bit 7 = PH8. Hex view (bit 0 as MSB): PH1=80, PH2=40, PH5=08.
- ph_idx, output, 3, registered binary index of last sampled phase (PH1=0 … PH8=7). 0 when not one-hot.
- ph_valid, output, 1, last sample was exactly one-hot.
- onehot_err, output, 1, one-cycle pulse: last sample was zero-hot or multi-hot.
- seq_err, output, 1, one-cycle pulse: last sample was a valid one-hot but an illegal successor.
- restart, output, 1, one-cycle pulse: entered PH1 from any non-PH1 phase.
- err_sticky, output, 1, set by any onehot_err or seq_err. Cleared only by reset.
- loop_count, output, CNT_W, count of PH<LOOP_LAST>→PH2 wraps. Wraps modulo 2^CNT_W.
- state, output, 2, FSM state for debug: 0 WAIT, 1 INIT, 2 LOOP.

Behaviour:
- Reset (reset=0, async) sets all outputs to 0 and state to WAIT. All outputs are registered.
- Sampling:
  - phase is sampled on every rising edge.
  - Outputs for the sample taken at edge N are visible after edge N (latency 1).
  - The prior sample is held internally as prev_idx / prev_valid.
- One-hot check:
  - popcount(phase) ≠ 1 → ph_valid=0, ph_idx=0, onehot_err=1.
  - State → WAIT.
  - Not also a seq_err in the same cycle.
- Legal successors of prev phase k (1-based):
  - k → k+1 for 1 ≤ k < LOOP_LAST.
  - LOOP_LAST → 2.
  - Any phase → PH1 (restart; sequencer re-init).
  - PH1 → PH1 (held in reset).
  - Anything else, including phases > LOOP_LAST or a repeat of PH2..PH8, gives seq_err=1 and state → WAIT.
- FSM:
  - WAIT:
    - Sample PH1 → INIT.
    - Any other valid phase stays in WAIT. No seq_err is checked in WAIT, since there is no trusted history.
    - Invalid sample stays in WAIT with onehot_err.
  - INIT:
    - PH1 stays.
    - PH2 → LOOP.
    - Other → WAIT with seq_err.
  - LOOP:
    - Legal successor stays in LOOP.
    - PH1 → INIT with restart=1.
    - Illegal → WAIT with seq_err.
- restart: pulses when PH1 is sampled and the previous sample was valid and not PH1. Not asserted on the first PH1 after reset.
- loop_count: increments in LOOP when prev=PH<LOOP_LAST> and current=PH2. Not incremented on the INIT→LOOP PH1→PH2 entry.
- Simultaneous events:
  - onehot_err and seq_err are mutually exclusive.
  - err_sticky sets in the same cycle the pulse asserts.
  - loop_count never increments in an error cycle.
- Reset mid-loop: everything returns to 0 / WAIT asynchronously. The first PH1 sampled after release re-enters INIT.

Optional Feature:
- Macro: PHASE_MON_CAPTURE_EN.
- Defined: adds outputs cap_prev [0:7] and cap_cur [0:7].
  - On the first error after reset (err_sticky rising), they latch the previous and current raw phase vectors.
  - Held until reset; reset value 00.
  - Later errors do not overwrite them.
- Undefined: the ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset low 100ns, then drive 80,40,20,10,08,40,20,10,08,40 → INIT then LOOP; loop_count=2; no error pulses; ph_idx follows 0,1,2,3,4,1,… one cycle late.
- In LOOP, drive 40 then 10 (PH2→PH4) → seq_err=1 for one cycle, err_sticky=1, state=WAIT. With capture enabled, cap_prev=40 and cap_cur=10.
- Drive 00, then C0 → onehot_err pulses on each; ph_valid=0; ph_idx=0; seq_err stays 0.
- In LOOP at PH3 (20), drive 80 → restart=1, state=INIT, no seq_err. Then 40 → LOOP with loop_count unchanged.
- With CNT_W=2, run 5 full loops → loop_count=1 (wrap).
- Assert reset mid-loop between edges → all outputs 0 immediately, before the next clock edge. After release, 80 → INIT and no restart pulse.
